max7219_spi_frame_tx: RTL and testbench
=======================================

MAX7219_SPI_FRAME_TX -- requirements
Module: max7219_spi_frame_tx

Interface
REQ-001 SHALL have parameter G_NB_MATRIX, default 8, number of cascaded MAX7219 devices (16-bit words) per frame, range 1..16.
REQ-002 SHALL have parameter G_MAX_HALF_PERIOD, default 4, clk cycles per SPI clock half-period, >=1.
REQ-003 SHALL have parameter G_LOAD_DURATION, default 4, clk cycles LOAD held high, >=1.
REQ-004 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port i_data  in  16  MAX7219 word {addr[15:8], data[7:0]}.
REQ-007 SHALL have port i_data_valid  in  1  word present on i_data.
REQ-008 SHALL have port o_data_ready  out  1  block can accept a word.
REQ-009 SHALL have port i_clear  in  1  synchronous abort of current frame.
REQ-010 SHALL have port o_busy  out  1  frame in progress (first word accepted until done).
REQ-011 SHALL have port o_done  out  1  one-cycle pulse, frame latched.
REQ-012 SHALL have ports o_max7219_clk, o_max7219_data, o_max7219_load  out  1 each  SPI lines to MAX7219 chain.

Function
REQ-013 SHALL implement states IDLE, SHIFT, WAIT_WORD, LOAD, DONE.
REQ-014 SHALL accept a word on any rising edge where i_data_valid and o_data_ready are both 1; o_data_ready SHALL be 1 only in IDLE and WAIT_WORD.
REQ-015 SHALL on acceptance latch i_data into a 16-bit shift register, increment word counter, go to SHIFT.
REQ-016 SHALL in SHIFT transmit 16 bits MSB first; per bit: o_max7219_data stable, o_max7219_clk low G_MAX_HALF_PERIOD cycles, then high G_MAX_HALF_PERIOD cycles; data changes only while clk low.
REQ-017 SHALL drive the first bit (bit 15) and clk low the cycle after acceptance; one word occupies exactly 32*G_MAX_HALF_PERIOD cycles.
REQ-018 SHALL after bit 0 high phase return clk low and go to WAIT_WORD if word counter < G_NB_MATRIX, else to LOAD.
REQ-019 SHALL in WAIT_WORD hold clk low, data at last value, load low, indefinitely until next word accepted.
REQ-020 SHALL in LOAD drive o_max7219_load high for exactly G_LOAD_DURATION cycles, clk low, then go to DONE.
REQ-021 SHALL in DONE assert o_done one cycle, clear word counter, return to IDLE; o_data_ready SHALL be 0 in DONE.
REQ-022 SHALL keep o_max7219_load low in every state except LOAD.
REQ-023 SHALL assert o_busy from the cycle after first acceptance through the DONE cycle inclusive.
REQ-024 SHALL on i_clear=1 in any state go to IDLE next cycle, clear counters and shift register, drive clk/data/load low, no load pulse, no o_done; i_clear has priority over acceptance.
REQ-025 SHALL ignore i_data_valid while o_data_ready=0 (no buffering, no loss of in-flight word).
REQ-026 SHALL use a word counter of width ceil(log2(G_NB_MATRIX+1)) and a bit counter 0..15 with no wrap during a frame.

Reset
REQ-027 SHALL while rst_n=0 force state IDLE, counters 0, shift register 0, o_max7219_clk/data/load=0, o_busy=0, o_done=0, o_data_ready=0.
REQ-028 SHALL assert o_data_ready the first cycle after rst_n release; reset mid-frame SHALL abort with no load pulse.

Verification
REQ-029 SHALL cover: G_NB_MATRIX=1, HP=4, word 16'h0C01 -> max7219_spi_checker frame 0x0C01, load high 4 cycles starting 128 cycles after acceptance, o_done 4 cycles later.
REQ-030 SHALL cover: G_NB_MATRIX=8, words 0x0101..0x0808 back-to-back -> exactly one load pulse after 8*128 cycles, checker sees all 8 words in order.
REQ-031 SHALL cover: 3 words, 50-cycle valid gap between 2nd and 3rd -> clk low, load low during gap, single load at end.
REQ-032 SHALL cover: valid held high during SHIFT with changing data -> only words presented while ready=1 transmitted.
REQ-033 SHALL cover: i_clear at bit 7 of word 2 -> lines low next cycle, no load, no o_done, new frame then sends correctly.
REQ-034 SHALL cover: rst_n low mid-LOAD -> load low asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/max7219_spi_frame_tx.sv
// Serialises G_NB_MATRIX 16-bit words MSB first to a MAX7219 chain (32*HP clk per word), then pulses LOAD and o_done.
// o_data_ready only in IDLE/WAIT_WORD; words offered at other times are neither taken nor buffered.
module max7219_spi_frame_tx #(
  parameter int G_NB_MATRIX       = 8,
  parameter int G_MAX_HALF_PERIOD = 4,
  parameter int G_LOAD_DURATION   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_data,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  input  logic        i_clear,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_max7219_clk,
  output logic        o_max7219_data,
  output logic        o_max7219_load
);

  localparam int WCW = $clog2(G_NB_MATRIX + 1);
  localparam int HCW = (G_MAX_HALF_PERIOD > 1) ? $clog2(G_MAX_HALF_PERIOD) : 1;
  localparam int LCW = (G_LOAD_DURATION > 1) ? $clog2(G_LOAD_DURATION) : 1;
  localparam logic [WCW-1:0] NB_W    = WCW'(G_NB_MATRIX);
  localparam logic [HCW-1:0] HC_LAST = HCW'(G_MAX_HALF_PERIOD - 1);
  localparam logic [LCW-1:0] LC_LAST = LCW'(G_LOAD_DURATION - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_WORD, LOAD, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [HCW-1:0]   hcnt_q, hcnt_d;
  logic [LCW-1:0]   lcnt_q, lcnt_d;
  logic             phase_q, phase_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             load_q, load_d;
  logic             rdy_q, rdy_d;
  logic             accept;

  // rdy_q is registered so ready stays low throughout reset and rises on the first edge after release.
  assign accept = i_data_valid & rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      load_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      load_q  <= load_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    phase_d = phase_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    load_d  = load_q;

    case (state_q)
      IDLE, WAIT_WORD: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = i_data;
          sdata_d = i_data[15];
          sclk_d  = 1'b0;
          wcnt_d  = wcnt_q + WCW'(1);
          bcnt_d  = '0;
          hcnt_d  = '0;
          phase_d = 1'b0;
        end
      end
      SHIFT: begin
        if (hcnt_q != HC_LAST) begin
          hcnt_d = hcnt_q + HCW'(1);
        end else begin
          hcnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            // End of a high phase: the only point where the data line may move.
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bcnt_q == 4'd15) begin
              bcnt_d = '0;
              if (wcnt_q < NB_W) begin
                state_d = WAIT_WORD;
              end else begin
                state_d = LOAD;
                load_d  = 1'b1;
                lcnt_d  = '0;
              end
            end else begin
              bcnt_d  = bcnt_q + 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
              sdata_d = shreg_q[14];
            end
          end
        end
      end
      LOAD: begin
        if (lcnt_q == LC_LAST) begin
          state_d = DONE;
          load_d  = 1'b0;
        end else begin
          lcnt_d = lcnt_q + LCW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        wcnt_d  = '0;
        lcnt_d  = '0;
        shreg_d = '0;
        sdata_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (i_clear) begin
      state_d = IDLE;
      shreg_d = '0;
      wcnt_d  = '0;
      bcnt_d  = '0;
      hcnt_d  = '0;
      lcnt_d  = '0;
      phase_d = 1'b0;
      sclk_d  = 1'b0;
      sdata_d = 1'b0;
      load_d  = 1'b0;
    end
  end

  assign rdy_d = (state_d == IDLE) || (state_d == WAIT_WORD);

  assign o_data_ready   = rdy_q;
  assign o_busy         = (state_q != IDLE);
  assign o_done         = (state_q == DONE);
  assign o_max7219_clk  = sclk_q;
  assign o_max7219_data = sdata_q;
  assign o_max7219_load = load_q;

endmodule

// File: tb/tb_max7219_spi_frame_tx.sv
// Directed bench: three chains (1, 3 and 8 devices, HP=4, LOAD=4) share stimulus; each task exercises one of them.
module tb_max7219_spi_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_data = 16'h0000;
  logic        i_data_valid = 1'b0;
  logic        i_clear = 1'b0;
  logic [2:0]  rdy, busy, done, sclk, sdata, load;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max7219_spi_frame_tx #(.G_NB_MATRIX(1), .G_MAX_HALF_PERIOD(4), .G_LOAD_DURATION(4)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(rdy[0]),
    .i_clear(i_clear), .o_busy(busy[0]), .o_done(done[0]), .o_max7219_clk(sclk[0]),
    .o_max7219_data(sdata[0]), .o_max7219_load(load[0]));

  max7219_spi_frame_tx #(.G_NB_MATRIX(3), .G_MAX_HALF_PERIOD(4), .G_LOAD_DURATION(4)) u_dut_n3 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(rdy[1]),
    .i_clear(i_clear), .o_busy(busy[1]), .o_done(done[1]), .o_max7219_clk(sclk[1]),
    .o_max7219_data(sdata[1]), .o_max7219_load(load[1]));

  max7219_spi_frame_tx #(.G_NB_MATRIX(8), .G_MAX_HALF_PERIOD(4), .G_LOAD_DURATION(4)) u_dut_n8 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(rdy[2]),
    .i_clear(i_clear), .o_busy(busy[2]), .o_done(done[2]), .o_max7219_clk(sclk[2]),
    .o_max7219_data(sdata[2]), .o_max7219_load(load[2]));

  // SPI receiver model: shifts data on each rising SPI clock, snapshots the stream when LOAD rises.
  logic [127:0] rx [3];
  logic [127:0] frame [3];
  int           nbits [3];
  int           frame_bits [3];
  int           loads [3];
  int           dones [3];
  int           dchg [3];
  logic [2:0]   p_sclk = 3'b000;
  logic [2:0]   p_sdata = 3'b000;
  logic [2:0]   p_load = 3'b000;

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (p_sclk[g] && sclk[g] && (sdata[g] !== p_sdata[g])) dchg[g] <= dchg[g] + 1;
      if (!p_sclk[g] && sclk[g]) begin
        rx[g]    <= {rx[g][126:0], sdata[g]};
        nbits[g] <= nbits[g] + 1;
      end
      if (!p_load[g] && load[g]) begin
        loads[g]      <= loads[g] + 1;
        frame[g]      <= rx[g];
        frame_bits[g] <= nbits[g];
      end
      if (done[g]) dones[g] <= dones[g] + 1;
    end
    p_sclk  <= sclk;
    p_sdata <= sdata;
    p_load  <= load;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    i_data_valid = 1'b0;
    i_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input int k, input logic [15:0] w);
    int n = 0;
    while (rdy[k] !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL send_ready_timeout: dut %0d ready=%b after %0d cycles, required 1", k, rdy[k], n);
    end
    i_data = w;
    i_data_valid = 1'b1;
    @(posedge clk); #1;
    i_data_valid = 1'b0;
  endtask

  task automatic wait_load(input int k, output int n);
    n = 0;
    while (load[k] !== 1'b1 && n < 1500) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({sclk[k], sdata[k], load[k], busy[k], done[k], rdy[k]} !== 6'b000000) begin
        errors++;
        $display("FAIL reset_outputs: dut %0d clk/data/load/busy/done/rdy=%b%b%b%b%b%b, required 000000",
                 k, sclk[k], sdata[k], load[k], busy[k], done[k], rdy[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy !== 3'b111 || busy !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b, required rdy=111 busy=000", rdy, busy);
    end
  endtask

  task automatic test_single_word();
    int n, m, l0, d0, b0;
    do_reset();
    l0 = loads[0]; d0 = dones[0]; b0 = nbits[0];
    send(0, 16'h0C01);
    checks++;
    if ({busy[0], rdy[0], sclk[0], sdata[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL single_first_bit: busy/rdy/clk/data=%b%b%b%b, required 1000", busy[0], rdy[0], sclk[0], sdata[0]);
    end
    wait_load(0, n);
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL single_load_latency: load rose %0d cycles after accept, required 128", n);
    end
    m = 0;
    while (load[0] === 1'b1 && m < 20) begin
      m++;
      @(posedge clk); #1;
    end
    checks++;
    if (m != 4) begin
      errors++;
      $display("FAIL single_load_width: load high %0d cycles, required 4", m);
    end
    checks++;
    if ({done[0], busy[0], rdy[0]} !== 3'b110) begin
      errors++;
      $display("FAIL single_done: done/busy/rdy=%b%b%b, required 110", done[0], busy[0], rdy[0]);
    end
    @(posedge clk); #1;
    checks++;
    if ({done[0], busy[0], rdy[0]} !== 3'b001) begin
      errors++;
      $display("FAIL single_idle: done/busy/rdy=%b%b%b, required 001", done[0], busy[0], rdy[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (frame[0][15:0] !== 16'h0C01 || frame_bits[0] - b0 != 16 || loads[0] - l0 != 1 || dones[0] - d0 != 1) begin
      errors++;
      $display("FAIL single_frame: word=%h bits=%0d loads=%0d dones=%0d, required 0c01/16/1/1",
               frame[0][15:0], frame_bits[0] - b0, loads[0] - l0, dones[0] - d0);
    end
  endtask

  task automatic test_back_to_back();
    int n, l0, d0, b0;
    logic [15:0] w;
    do_reset();
    l0 = loads[2]; d0 = dones[2]; b0 = nbits[2];
    for (int i = 1; i <= 8; i++) begin
      w = {i[7:0], i[7:0]};
      send(2, w);
      if (i == 4) begin
        checks++;
        if (loads[2] != l0 || busy[2] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_midframe: loads=%0d busy=%b, required 0/1", loads[2] - l0, busy[2]);
        end
      end
    end
    wait_load(2, n);
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL b2b_load_latency: load rose %0d cycles after last accept, required 128", n);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (frame[2] !== 128'h0101_0202_0303_0404_0505_0606_0707_0808 || frame_bits[2] - b0 != 128) begin
      errors++;
      $display("FAIL b2b_frame: got %h (%0d bits), required 01010202030304040505060607070808 (128 bits)",
               frame[2], frame_bits[2] - b0);
    end
    checks++;
    if (loads[2] - l0 != 1 || dones[2] - d0 != 1) begin
      errors++;
      $display("FAIL b2b_pulses: loads=%0d dones=%0d, required 1/1", loads[2] - l0, dones[2] - d0);
    end
  endtask

  task automatic test_wait_gap();
    int n, bad, l0, b0;
    do_reset();
    l0 = loads[1]; b0 = nbits[1];
    send(1, 16'h0A11);
    send(1, 16'h0B23);
    n = 0;
    while (rdy[1] !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL gap_wait_entry: ready after %0d cycles, required 128", n);
    end
    bad = 0;
    for (int j = 0; j < 50; j++) begin
      if (sclk[1] !== 1'b0 || load[1] !== 1'b0 || sdata[1] !== 1'b1 || busy[1] !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gap_lines_idle: %0d gap cycles with clk!=0, load!=0, data!=1 or busy!=1, required 0", bad);
    end
    send(1, 16'h0C33);
    wait_load(1, n);
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL gap_load_latency: load rose %0d cycles after last accept, required 128", n);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (frame[1][47:0] !== 48'h0A11_0B23_0C33 || frame_bits[1] - b0 != 48 || loads[1] - l0 != 1) begin
      errors++;
      $display("FAIL gap_frame: got %h bits=%0d loads=%0d, required 0a110b230c33/48/1",
               frame[1][47:0], frame_bits[1] - b0, loads[1] - l0);
    end
  endtask

  task automatic test_valid_held();
    int acc, j, n, l0, b0;
    logic [47:0] exp;
    do_reset();
    l0 = loads[1]; b0 = nbits[1];
    exp = '0; acc = 0; j = 0;
    i_data = 16'h5000;
    i_data_valid = 1'b1;
    while (acc < 3 && j < 2000) begin
      if (rdy[1] === 1'b1) begin
        exp = {exp[31:0], i_data};
        acc++;
      end
      @(posedge clk); #1;
      j++;
      i_data = i_data + 16'h0111;
    end
    i_data_valid = 1'b0;
    checks++;
    if (acc != 3) begin
      errors++;
      $display("FAIL held_accepts: %0d words accepted, required 3", acc);
    end
    wait_load(1, n);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (frame[1][47:0] !== exp || frame_bits[1] - b0 != 48 || loads[1] - l0 != 1) begin
      errors++;
      $display("FAIL held_frame: got %h bits=%0d loads=%0d, required %h/48/1",
               frame[1][47:0], frame_bits[1] - b0, loads[1] - l0, exp);
    end
    checks++;
    if (dchg[1] != 0) begin
      errors++;
      $display("FAIL held_data_stable: %0d data changes while clk high, required 0", dchg[1]);
    end
  endtask

  task automatic test_clear();
    int n, l0, d0, b0;
    logic [15:0] w;
    logic [127:0] exp;
    do_reset();
    l0 = loads[2]; d0 = dones[2];
    send(2, 16'h1111);
    send(2, 16'h22A2);
    repeat (66) @(posedge clk);
    #1;
    checks++;
    if ({sclk[2], sdata[2], busy[2]} !== 3'b011) begin
      errors++;
      $display("FAIL clear_at_bit7: clk/data/busy=%b%b%b, required 011", sclk[2], sdata[2], busy[2]);
    end
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    checks++;
    if ({sclk[2], sdata[2], load[2], busy[2], done[2], rdy[2]} !== 6'b000001) begin
      errors++;
      $display("FAIL clear_lines: clk/data/load/busy/done/rdy=%b%b%b%b%b%b, required 000001",
               sclk[2], sdata[2], load[2], busy[2], done[2], rdy[2]);
    end
    i_data = 16'hFFFF;
    i_data_valid = 1'b1;
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_data_valid = 1'b0;
    i_clear = 1'b0;
    checks++;
    if (busy[2] !== 1'b0 || rdy[2] !== 1'b1) begin
      errors++;
      $display("FAIL clear_priority: busy=%b rdy=%b, required 0/1", busy[2], rdy[2]);
    end
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (loads[2] != l0 || dones[2] != d0) begin
      errors++;
      $display("FAIL clear_no_pulse: loads=%0d dones=%0d, required 0/0", loads[2] - l0, dones[2] - d0);
    end
    b0 = nbits[2];
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      w = 16'h4000 + 16'(i) * 16'h0123;
      exp = {exp[111:0], w};
      send(2, w);
    end
    wait_load(2, n);
    checks++;
    if (n != 128) begin
      errors++;
      $display("FAIL clear_refill_latency: load rose %0d cycles after last accept, required 128", n);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (frame[2] !== exp || frame_bits[2] - b0 != 128 || loads[2] - l0 != 1 || dones[2] - d0 != 1) begin
      errors++;
      $display("FAIL clear_refill_frame: got %h bits=%0d loads=%0d dones=%0d, required %h/128/1/1",
               frame[2], frame_bits[2] - b0, loads[2] - l0, dones[2] - d0, exp);
    end
  endtask

  task automatic test_reset_mid_load();
    int n, d0;
    do_reset();
    d0 = dones[0];
    send(0, 16'h0F0F);
    wait_load(0, n);
    @(posedge clk); #1;
    checks++;
    if (load[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstload_in_load: load=%b after %0d cycles, required 1", load[0], n);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sclk[0], sdata[0], load[0], busy[0], done[0], rdy[0]} !== 6'b000000) begin
      errors++;
      $display("FAIL rstload_async: clk/data/load/busy/done/rdy=%b%b%b%b%b%b, required 000000",
               sclk[0], sdata[0], load[0], busy[0], done[0], rdy[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstload_release: rdy=%b busy=%b, required 1/0", rdy[0], busy[0]);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (dones[0] != d0 || load[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstload_no_done: dones=%0d load=%b, required 0/0", dones[0] - d0, load[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_wait_gap();
    test_valid_held();
    test_clear();
    test_reset_mid_load();
    checks++;
    if (dchg[0] != 0 || dchg[2] != 0) begin
      errors++;
      $display("FAIL data_stable_high: changes while clk high n1=%0d n8=%0d, required 0/0", dchg[0], dchg[2]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
